hazard_flush_ctrl: RTL
======================

// Module: hazard_flush_ctrl
// PURPOSE
//  Pipeline hazard controller for the 5-stage RV32 core. Generates the per-stage stall and flush
//  controls consumed by the pipeline registers and the EX-stage control masking logic (FlushE
//  zeroes the EX control bundle). Resolves load-use hazards, taken branches/jumps and data-memory
//  wait states. Provides a post-reset bubble sequence, a memory-timeout error flag and
//  saturating stall/flush event counters.
// PARAMETERS
//  RESET_FLUSH_CYCLES  3   cycles after reset release with FlushD/FlushE forced (pipeline init)
//  MEM_TIMEOUT         255 max consecutive MemBusy cycles before MemTimeout is set
//  CNT_W               16  width of StallCount / FlushCount
// PORTS
//  CLK         in   1      core clock, rising edge
//  RESET       in   1      asynchronous, active-high reset
//  MemReadE    in   1      instruction in EX is a load
//  RdE         in   5      destination register of EX instruction
//  Rs1D        in   5      rs1 of ID instruction
//  Rs2D        in   5      rs2 of ID instruction
//  Rs1UsedD    in   1      ID instruction reads rs1
//  Rs2UsedD    in   1      ID instruction reads rs2
//  PCSelectE   in   1      taken branch/jump resolved in EX (already masked by FlushE upstream)
//  MemBusy     in   1      data memory not ready; MEM-stage access must hold
//  StallF      out  1      hold PC
//  StallD      out  1      hold IF/ID register
//  StallE      out  1      hold ID/EX register
//  StallM      out  1      hold EX/MEM register
//  FlushD      out  1      clear IF/ID register (insert NOP)
//  FlushE      out  1      clear ID/EX control bundle
//  FlushW      out  1      clear MEM/WB register (bubble into WB)
//  MemTimeout  out  1      sticky: MemBusy exceeded MEM_TIMEOUT consecutive cycles
//  StallCount  out  CNT_W  saturating count of cycles with StallF=1
//  FlushCount  out  CNT_W  saturating count of cycles with FlushE=1
// BEHAVIOUR
//  - Reset (async assert): state=INIT, init_cnt=RESET_FLUSH_CYCLES, busy_cnt=0, MemTimeout=0,
//    counters=0. During RESET all stall/flush outputs = 0.
//  - Stall/flush outputs are combinational from inputs + registered state (0-cycle latency).
//  - States: INIT -> RUN when init_cnt reaches 0; RUN <-> MEMWAIT on MemBusy.
//  - INIT: StallF=1, FlushD=1, FlushE=1, others 0; init_cnt decrements each cycle. INIT ignores
//    MemBusy/PCSelectE/load-use. RESET_FLUSH_CYCLES=0 -> go straight to RUN after reset.
//  - Priority in RUN/MEMWAIT (highest first):
//    1. MemBusy=1: StallF=StallD=StallE=StallM=1, FlushW=1, FlushD=FlushE=0; state=MEMWAIT.
//       A taken branch in EX is frozen and acted on in the first cycle MemBusy=0.
//    2. PCSelectE=1: FlushD=1, FlushE=1, no stalls (load-use in ID is discarded by the flush).
//    3. Load-use: MemReadE && RdE!=0 && ((Rs1UsedD && Rs1D==RdE) || (Rs2UsedD && Rs2D==RdE))
//       -> StallF=StallD=1, FlushE=1. Exactly one bubble; next cycle the load is in MEM.
//    4. Otherwise all outputs 0.
//  - MEMWAIT -> RUN in the first cycle MemBusy=0 (that cycle evaluated by rules 2-4).
//  - busy_cnt: +1 each cycle MemBusy=1 (saturates at MEM_TIMEOUT+1), cleared when MemBusy=0.
//    MemTimeout set on the edge where busy_cnt would exceed MEM_TIMEOUT; stays 1 until RESET.
//    MemTimeout does not alter stall/flush behaviour.
//  - StallCount/FlushCount: +1 on each clock edge with StallF=1 / FlushE=1 (INIT included);
//    saturate at 2^CNT_W-1, never wrap.
//  - RESET mid-operation (e.g. in MEMWAIT): all state cleared immediately, INIT restarts on release.
// TESTING
//  - Reset release, RESET_FLUSH_CYCLES=3 -> StallF/FlushD/FlushE=1 for exactly 3 cycles, then 0;
//    StallCount=FlushCount=3.
//  - MemReadE=1, RdE=5, Rs1D=5, Rs1UsedD=1 -> one cycle StallF=StallD=FlushE=1; RdE=0 -> no stall;
//    Rs2D=5 with Rs2UsedD=0 -> no stall.
//  - PCSelectE=1 with simultaneous load-use match -> FlushD=FlushE=1, StallF=StallD=0.
//  - MemBusy=1 for 4 cycles with PCSelectE=1 -> 4 cycles StallF..StallM=1, FlushW=1,
//    FlushD=FlushE=0; 5th cycle FlushD=FlushE=1.
//  - MEM_TIMEOUT=4, MemBusy high 5 cycles -> MemTimeout=1 after 5th edge, remains 1 after MemBusy
//    drops; MemBusy high exactly 4 cycles -> stays 0.
//  - CNT_W=4, 20 load-use stalls -> StallCount holds at 15; RESET asserted in MEMWAIT -> outputs
//    0 immediately, INIT sequence replays on release.

Source files
------------

// File: rtl/hazard_flush_ctrl.sv
// hazard_flush_ctrl: per-stage stall/flush generation for the 5-stage RV32 pipeline
module hazard_flush_ctrl #(
  parameter int RESET_FLUSH_CYCLES = 3,
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             MemReadE,
  input  logic [4:0]       RdE,
  input  logic [4:0]       Rs1D,
  input  logic [4:0]       Rs2D,
  input  logic             Rs1UsedD,
  input  logic             Rs2UsedD,
  input  logic             PCSelectE,
  input  logic             MemBusy,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             StallM,
  output logic             FlushD,
  output logic             FlushE,
  output logic             FlushW,
  output logic             MemTimeout,
  output logic [CNT_W-1:0] StallCount,
  output logic [CNT_W-1:0] FlushCount
);
  localparam int IW = RESET_FLUSH_CYCLES > 0 ? $clog2(RESET_FLUSH_CYCLES + 1) : 1;
  localparam int BW = $clog2(MEM_TIMEOUT + 2);
  typedef enum logic [1:0] {INIT, RUN, MEMWAIT} state_t;
  state_t state, stateNext;
  logic [IW-1:0] initCnt;
  logic [BW-1:0] busyCnt;
  logic loadUse, inInit, inRun, busy, branch, luStall;
  assign loadUse = MemReadE && RdE != 5'd0 &&
                   ((Rs1UsedD && Rs1D == RdE) || (Rs2UsedD && Rs2D == RdE));
  always_ff @(posedge CLK or posedge RESET)
    if (RESET) begin
      state   <= RESET_FLUSH_CYCLES == 0 ? RUN : INIT;
      initCnt <= IW'(RESET_FLUSH_CYCLES);
    end else begin
      state <= stateNext;
      if (state == INIT) initCnt <= initCnt - 1'b1;
    end
  always_comb begin
    stateNext = state;
    if (state == INIT) stateNext = initCnt <= IW'(1) ? RUN : INIT;
    else stateNext = MemBusy ? MEMWAIT : RUN;
  end
  // outputs are forced low while RESET is held, even though state already reads INIT
  always_comb begin
    inInit  = !RESET && state == INIT;
    inRun   = !RESET && state != INIT;
    busy    = inRun && MemBusy;
    branch  = inRun && !MemBusy && PCSelectE;
    luStall = inRun && !MemBusy && !PCSelectE && loadUse;
    StallF  = inInit || busy || luStall;
    StallD  = busy || luStall;
    StallE  = busy;
    StallM  = busy;
    FlushD  = inInit || branch;
    FlushE  = inInit || branch || luStall;
    FlushW  = busy;
  end
  always_ff @(posedge CLK or posedge RESET)
    if (RESET) begin
      busyCnt    <= '0;
      MemTimeout <= 1'b0;
      StallCount <= '0;
      FlushCount <= '0;
    end else begin
      busyCnt <= !MemBusy ? '0 : busyCnt == BW'(MEM_TIMEOUT + 1) ? busyCnt : busyCnt + 1'b1;
      if (MemBusy && busyCnt >= BW'(MEM_TIMEOUT)) MemTimeout <= 1'b1;
      if (StallF && StallCount != '1) StallCount <= StallCount + 1'b1;
      if (FlushE && FlushCount != '1) FlushCount <= FlushCount + 1'b1;
    end
endmodule
